// File: rtl/bus_master_ctrl_if.sv
// Command, arbiter and serial bus signals between a master core and its
// transaction controller. The master modport is the controller's view.
interface bus_master_ctrl_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
);
    logic              start;
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              grant;
    logic              slave_ready;
    logic              rx_bit;
    logic              rx_valid;
    logic              request;
    logic              tx_bit;
    logic              tx_valid;
    logic              mode;
    logic [DATA_W-1:0] rdata;
    logic              done;
    logic              error;
    logic              busy;

    modport master (
        input  start, rw, addr, wdata, grant, slave_ready, rx_bit, rx_valid,
        output request, tx_bit, tx_valid, mode, rdata, done, error, busy
    );

    modport slave (
        output start, rw, addr, wdata, grant, slave_ready, rx_bit, rx_valid,
        input  request, tx_bit, tx_valid, mode, rdata, done, error, busy
    );
endinterface

// File: rtl/bus_master_ctrl.sv
// Master-side bus transaction controller: requests the bus, serialises address
// and write data LSB-first, waits for the slave and deserialises read data.
module bus_master_ctrl #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input logic               clk,
    input logic               reset,
    bus_master_ctrl_if.master bus
);
    localparam int MAX_W  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int CNT_W  = $clog2(MAX_W);
    localparam int TMR_W  = $clog2(TIMEOUT);
    localparam int AIDX_W = $clog2(ADDR_W);
    localparam int DIDX_W = $clog2(DATA_W);

    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, REQ, ADDR, WDATA, WAIT_RDY, RDATA, DONE, ERR
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [TMR_W-1:0]  timer;
    logic [CNT_W-1:0]  bit_cnt;
    logic              rw_l;
    logic [ADDR_W-1:0] addr_l;
    logic [DATA_W-1:0] wdata_l;
    logic [DATA_W-1:0] shadow;
    logic [DATA_W-1:0] shadow_next;
    logic [DATA_W-1:0] rdata_r;

    logic request_c;
    logic tx_bit_c;
    logic tx_valid_c;
    logic done_c;
    logic error_c;
    logic busy_c;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Losing grant while holding the bus outranks every other event.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (bus.start) next_state = REQ;
            end
            REQ: begin
                if (bus.grant)              next_state = ADDR;
                else if (timer == TMR_LAST) next_state = ERR;
            end
            ADDR: begin
                if (!bus.grant)                next_state = ERR;
                else if (bit_cnt == ADDR_LAST) next_state = rw_l ? WDATA : WAIT_RDY;
            end
            WDATA: begin
                if (!bus.grant)                next_state = ERR;
                else if (bit_cnt == DATA_LAST) next_state = WAIT_RDY;
            end
            WAIT_RDY: begin
                if (!bus.grant)             next_state = ERR;
                else if (bus.slave_ready)   next_state = rw_l ? DONE : RDATA;
                else if (timer == TMR_LAST) next_state = ERR;
            end
            RDATA: begin
                if (!bus.grant) begin
                    next_state = ERR;
                end else if (bus.rx_valid) begin
                    if (bit_cnt == DATA_LAST) next_state = DONE;
                end else if (timer == TMR_LAST) begin
                    next_state = ERR;
                end
            end
            DONE:    next_state = IDLE;
            ERR:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        shadow_next = shadow;
        if (state == RDATA && bus.rx_valid) begin
            shadow_next[bit_cnt[DIDX_W-1:0]] = bus.rx_bit;
        end
    end

    // Both counters restart on every state change, so neither can wrap.
    always_ff @(posedge clk) begin
        if (!reset) begin
            timer   <= '0;
            bit_cnt <= '0;
            rw_l    <= 1'b0;
            addr_l  <= '0;
            wdata_l <= '0;
            shadow  <= '0;
            rdata_r <= '0;
        end else begin
            if (state != next_state) begin
                timer   <= '0;
                bit_cnt <= '0;
            end else begin
                case (state)
                    REQ, WAIT_RDY: timer <= timer + 1'b1;
                    ADDR, WDATA:   bit_cnt <= bit_cnt + 1'b1;
                    RDATA: begin
                        if (bus.rx_valid) begin
                            timer   <= '0;
                            bit_cnt <= bit_cnt + 1'b1;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end

            if (state == IDLE && bus.start) begin
                rw_l    <= bus.rw;
                addr_l  <= bus.addr;
                wdata_l <= bus.wdata;
                shadow  <= '0;
            end else begin
                shadow <= shadow_next;
            end

            // Committing on entry to DONE makes rdata valid during the done pulse.
            if (state == RDATA && next_state == DONE) begin
                rdata_r <= shadow_next;
            end
        end
    end

    always_comb begin
        request_c  = 1'b0;
        tx_bit_c   = 1'b0;
        tx_valid_c = 1'b0;
        done_c     = 1'b0;
        error_c    = 1'b0;
        busy_c     = (state != IDLE);
        case (state)
            REQ, WAIT_RDY, RDATA: request_c = 1'b1;
            ADDR: begin
                request_c  = 1'b1;
                tx_valid_c = 1'b1;
                tx_bit_c   = addr_l[bit_cnt[AIDX_W-1:0]];
            end
            WDATA: begin
                request_c  = 1'b1;
                tx_valid_c = 1'b1;
                tx_bit_c   = wdata_l[bit_cnt[DIDX_W-1:0]];
            end
            DONE:    done_c  = 1'b1;
            ERR:     error_c = 1'b1;
            default: ;
        endcase
    end

    assign bus.request  = request_c;
    assign bus.tx_bit   = tx_bit_c;
    assign bus.tx_valid = tx_valid_c;
    assign bus.mode     = busy_c & rw_l;
    assign bus.rdata    = rdata_r;
    assign bus.done     = done_c;
    assign bus.error    = error_c;
    assign bus.busy     = busy_c;
endmodule

// File: tb/tb_bus_master_ctrl.sv
// Randomised self-checking bench for bus_master_ctrl; expectations come from a
// per-transaction timeline computed from the protocol rules.
module tb_bus_master_ctrl;
    localparam int ADDR_W  = 12;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 16;
    localparam int MAXC    = 512;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    bus_master_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    bus_master_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    logic [DATA_W-1:0] rdata_exp = '0;

    // Per-cycle input schedules for the transaction in flight.
    logic g_s [MAXC];
    logic r_s [MAXC];
    logic v_s [MAXC];
    logic b_s [MAXC];
    int   gap_s [DATA_W];

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic applyStimulus(input int c, input bit junk, input bit rst_now);
        bus.grant       = g_s[c];
        bus.slave_ready = r_s[c];
        bus.rx_valid    = v_s[c];
        bus.rx_bit      = b_s[c];
        reset           = !rst_now;
        if (junk) begin
            bus.start = 1'b1;
            bus.rw    = 1'($urandom);
            bus.addr  = ADDR_W'($urandom);
            bus.wdata = DATA_W'($urandom);
        end else begin
            bus.start = 1'b0;
        end
    endtask

    task automatic checkIdle(input string pfx, input int c);
        checkOutput($sformatf("%s busy c%0d", pfx, c),     32'(bus.busy), 32'(0));
        checkOutput($sformatf("%s request c%0d", pfx, c),  32'(bus.request), 32'(0));
        checkOutput($sformatf("%s tx_valid c%0d", pfx, c), 32'(bus.tx_valid), 32'(0));
        checkOutput($sformatf("%s mode c%0d", pfx, c),     32'(bus.mode), 32'(0));
        checkOutput($sformatf("%s done c%0d", pfx, c),     32'(bus.done), 32'(0));
        checkOutput($sformatf("%s error c%0d", pfx, c),    32'(bus.error), 32'(0));
        checkOutput($sformatf("%s rdata c%0d", pfx, c),    32'(bus.rdata), 32'(rdata_exp));
    endtask

    // Called just after a negedge in an idle cycle; issues start for edge 0.
    task automatic run_txn(input logic t_rw, input logic [ADDR_W-1:0] t_addr,
                           input logic [DATA_W-1:0] t_wdata, input logic [DATA_W-1:0] t_word,
                           input int gdly, input int rdly, input int drop, input int rst_in);
        int  t_a, t_w, t_r, t_end, s, endc, idx, rst_cyc;
        bit  ok, fin, in_tx;
        logic exp_bit;
        for (int i = 0; i < MAXC; i++) begin
            g_s[i] = 1'($urandom);
            r_s[i] = 1'($urandom);
            v_s[i] = 1'($urandom);
            b_s[i] = 1'($urandom);
        end
        ok = 1'b0;
        t_a = MAXC;
        t_w = MAXC;
        if (gdly >= TIMEOUT) begin
            t_end = TIMEOUT + 1;
            for (int c = 1; c <= t_end; c++) g_s[c] = 1'b0;
        end else begin
            for (int c = 1; c <= gdly; c++) g_s[c] = 1'b0;
            for (int c = gdly + 1; c < MAXC; c++) g_s[c] = 1'b1;
            t_a = 2 + gdly;
            t_w = t_a + ADDR_W + (t_rw ? DATA_W : 0);
            if (rdly >= TIMEOUT) begin
                for (int c = t_w; c < t_w + TIMEOUT; c++) r_s[c] = 1'b0;
                t_end = t_w + TIMEOUT;
            end else begin
                for (int c = t_w; c < t_w + rdly; c++) r_s[c] = 1'b0;
                r_s[t_w + rdly] = 1'b1;
                if (t_rw) begin
                    t_end = t_w + rdly + 1;
                    ok = 1'b1;
                end else begin
                    t_r = t_w + rdly + 1;
                    s = t_r;
                    fin = 1'b1;
                    t_end = 0;
                    for (int i = 0; i < DATA_W; i++) begin
                        if (fin) begin
                            if (gap_s[i] >= TIMEOUT) begin
                                for (int c = s; c < s + TIMEOUT; c++) v_s[c] = 1'b0;
                                t_end = s + TIMEOUT;
                                fin = 1'b0;
                            end else begin
                                for (int c = s; c < s + gap_s[i]; c++) v_s[c] = 1'b0;
                                v_s[s + gap_s[i]] = 1'b1;
                                b_s[s + gap_s[i]] = t_word[i];
                                s = s + gap_s[i] + 1;
                            end
                        end
                    end
                    if (fin) begin
                        t_end = s;
                        ok = 1'b1;
                    end
                end
            end
            if (drop >= 0 && t_a + drop < t_end) begin
                g_s[t_a + drop] = 1'b0;
                t_end = t_a + drop + 1;
                ok = 1'b0;
            end
        end
        rst_cyc = (rst_in > 0 && rst_in < t_end) ? rst_in : 0;
        endc = (rst_cyc > 0) ? rst_cyc + 1 : t_end + 1;

        bus.start = 1'b1;
        bus.rw    = t_rw;
        bus.addr  = t_addr;
        bus.wdata = t_wdata;
        for (int c = 1; c <= endc; c++) begin
            @(posedge clk);
            #1;
            applyStimulus(c, c < endc, c == rst_cyc);
            @(negedge clk);
            if (rst_cyc > 0 && c == endc) begin
                rdata_exp = '0;
                checkOutput($sformatf("rst tx_bit c%0d", c), 32'(bus.tx_bit), 32'(0));
                checkIdle("rst", c);
            end else if (c <= t_end) begin
                in_tx = (c < t_end) && (c >= t_a) && (c < t_w);
                if (c == t_end && ok && !t_rw) rdata_exp = t_word;
                checkOutput($sformatf("busy c%0d", c),     32'(bus.busy), 32'(1));
                checkOutput($sformatf("request c%0d", c),  32'(bus.request), 32'(c < t_end));
                checkOutput($sformatf("mode c%0d", c),     32'(bus.mode), 32'(t_rw));
                checkOutput($sformatf("done c%0d", c),     32'(bus.done), 32'(c == t_end && ok));
                checkOutput($sformatf("error c%0d", c),    32'(bus.error), 32'(c == t_end && !ok));
                checkOutput($sformatf("tx_valid c%0d", c), 32'(bus.tx_valid), 32'(in_tx));
                checkOutput($sformatf("rdata c%0d", c),    32'(bus.rdata), 32'(rdata_exp));
                if (in_tx) begin
                    idx = c - t_a;
                    if (idx < ADDR_W) exp_bit = t_addr[idx];
                    else              exp_bit = t_wdata[idx - ADDR_W];
                    checkOutput($sformatf("tx_bit c%0d", c), 32'(bus.tx_bit), 32'(exp_bit));
                end
            end else begin
                checkIdle("idle", c);
            end
        end
    endtask

    initial begin
        int r, gdly, rdly, drop, rstc;
        logic t_rw;
        logic [ADDR_W-1:0] t_addr;
        logic [DATA_W-1:0] t_wdata, t_word;

        bus.start = 1'b0; bus.rw = 1'b0; bus.addr = '0; bus.wdata = '0;
        bus.grant = 1'b0; bus.slave_ready = 1'b0; bus.rx_bit = 1'b0; bus.rx_valid = 1'b0;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset tx_bit", 32'(bus.tx_bit), 32'(0));
        checkIdle("reset", 0);
        reset = 1'b1;
        @(negedge clk);
        checkIdle("post_reset", 0);

        for (int i = 0; i < DATA_W; i++) gap_s[i] = 0;
        // Best-case write: done in cycle 23.
        run_txn(1'b1, 12'hA5C, 8'h3C, 8'h00, 0, 0, -1, 0);
        // Read, slave ready in cycle 15, two rx_valid gaps.
        gap_s[2] = 1;
        gap_s[5] = 1;
        run_txn(1'b0, 12'h001, 8'h00, 8'h55, 0, 1, -1, 0);
        for (int i = 0; i < DATA_W; i++) gap_s[i] = 0;
        // Grant never arrives: error in cycle 17.
        run_txn(1'b1, 12'h123, 8'h9A, 8'h00, TIMEOUT, 0, -1, 0);
        // Grant lost on the 5th address bit, then a normal command right after.
        run_txn(1'b0, 12'hFFF, 8'h00, 8'hC3, 0, 0, 4, 0);
        run_txn(1'b1, 12'h5A5, 8'hE1, 8'h00, 2, 3, -1, 0);
        // Reset in the middle of RDATA.
        run_txn(1'b0, 12'h0F0, 8'h00, 8'hA7, 0, 0, -1, 18);
        // slave_ready on the same cycle the timer expires.
        run_txn(1'b1, 12'h777, 8'h18, 8'h00, 0, TIMEOUT - 1, -1, 0);
        run_txn(1'b0, 12'h321, 8'h00, 8'h6B, TIMEOUT - 1, TIMEOUT - 1, -1, 0);

        for (int n = 0; n < 150; n++) begin
            t_rw    = 1'($urandom);
            t_addr  = ADDR_W'($urandom);
            t_wdata = DATA_W'($urandom);
            t_word  = DATA_W'($urandom);
            r = int'($urandom % 16);
            gdly = (r == 0) ? TIMEOUT + int'($urandom % 2) : (r == 1) ? TIMEOUT - 1 : int'($urandom % 4);
            r = int'($urandom % 16);
            rdly = (r == 0) ? TIMEOUT + int'($urandom % 2) : (r == 1) ? TIMEOUT - 1 : int'($urandom % 4);
            for (int i = 0; i < DATA_W; i++) begin
                r = int'($urandom % 32);
                gap_s[i] = (r == 0) ? TIMEOUT : (r == 1) ? TIMEOUT - 1 : int'($urandom % 3);
            end
            drop = (($urandom % 6) == 0) ? int'($urandom % 40) : -1;
            rstc = (($urandom % 16) == 0) ? 1 + int'($urandom % 60) : 0;
            run_txn(t_rw, t_addr, t_wdata, t_word, gdly, rdly, drop, rstc);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
